// File: rtl/exec_cdb_unit_if.sv
// rtl/exec_cdb_unit_if.sv - lane dispatch and CDB read-out bundle for the execution slice
interface exec_cdb_unit_if #(
  parameter int NUM_LANES = 4,
  parameter int NUM_TAGS  = 8,
  parameter int XLEN      = 32
);
  localparam int TAG_W = $clog2(NUM_TAGS);

  logic [NUM_LANES-1:0]                  exec;
  logic [NUM_LANES-1:0]                  op_imm;
  logic [NUM_LANES-1:0][2:0]             funct3;
  logic [NUM_LANES-1:0]                  funct7_b5;
  logic [NUM_LANES-1:0][XLEN-1:0]        src1;
  logic [NUM_LANES-1:0][XLEN-1:0]        src2;
  logic [NUM_LANES-1:0][TAG_W-1:0]       tag;
  logic [NUM_TAGS-1:0]                   clr_valid;
  logic [NUM_LANES-1:0][XLEN-1:0]        alu_result;
  logic [NUM_TAGS-1:0]                   set_rob_valid;
  logic [NUM_TAGS-1:0][XLEN-1:0]         cdb_data;
  logic [NUM_TAGS-1:0]                   cdb_valid;

  modport master (
    output exec, op_imm, funct3, funct7_b5, src1, src2, tag, clr_valid,
    input  alu_result, set_rob_valid, cdb_data, cdb_valid
  );

  modport slave (
    input  exec, op_imm, funct3, funct7_b5, src1, src2, tag, clr_valid,
    output alu_result, set_rob_valid, cdb_data, cdb_valid
  );
endinterface

// File: rtl/exec_cdb_unit.sv
// rtl/exec_cdb_unit.sv - four RV32I ALU lanes writing a tag-indexed common data bus
module exec_cdb_unit #(
  parameter int NUM_LANES = 4,
  parameter int NUM_TAGS  = 8,
  parameter int XLEN      = 32
) (
  input logic             clk,
  input logic             rst,
  exec_cdb_unit_if.slave  bus
);
  localparam int SH_W = $clog2(XLEN);

  logic [NUM_LANES-1:0][XLEN-1:0] result;
  logic [NUM_TAGS-1:0]            set_mask;
  logic [NUM_TAGS-1:0][XLEN-1:0]  data_q;
  logic [NUM_TAGS-1:0]            valid_q;

  always_comb begin
    result = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      case (bus.funct3[l])
        3'b000: result[l] = (!bus.op_imm[l] && bus.funct7_b5[l]) ? bus.src1[l] - bus.src2[l]
                                                                  : bus.src1[l] + bus.src2[l];
        3'b001: result[l] = bus.src1[l] << bus.src2[l][SH_W-1:0];
        3'b010: result[l] = {{(XLEN-1){1'b0}}, $signed(bus.src1[l]) < $signed(bus.src2[l])};
        3'b011: result[l] = {{(XLEN-1){1'b0}}, bus.src1[l] < bus.src2[l]};
        3'b100: result[l] = bus.src1[l] ^ bus.src2[l];
        3'b101: begin
          // $unsigned keeps the shift self-determined so >>> stays arithmetic
          if (bus.funct7_b5[l])
            result[l] = $unsigned($signed(bus.src1[l]) >>> bus.src2[l][SH_W-1:0]);
          else
            result[l] = bus.src1[l] >> bus.src2[l][SH_W-1:0];
        end
        3'b110: result[l] = bus.src1[l] | bus.src2[l];
        default: result[l] = bus.src1[l] & bus.src2[l];
      endcase
    end
  end

  always_comb begin
    set_mask = '0;
    for (int l = 0; l < NUM_LANES; l++)
      if (bus.exec[l]) set_mask[bus.tag[l]] = 1'b1;
  end

  // Later assignments win: lane writes override clears, higher lanes override lower ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= '0;
    end else begin
      for (int t = 0; t < NUM_TAGS; t++)
        if (bus.clr_valid[t]) valid_q[t] <= 1'b0;
      for (int l = 0; l < NUM_LANES; l++) begin
        if (bus.exec[l]) begin
          data_q[bus.tag[l]]  <= result[l];
          valid_q[bus.tag[l]] <= 1'b1;
        end
      end
    end
  end

  assign bus.alu_result    = result;
  assign bus.set_rob_valid = set_mask;
  assign bus.cdb_data      = data_q;
  assign bus.cdb_valid     = valid_q;
endmodule

// File: tb/tb_exec_cdb_unit.sv
// tb/tb_exec_cdb_unit.sv - randomized and directed self-check of exec_cdb_unit
module tb_exec_cdb_unit;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  logic [31:0] m_data  [8];
  bit          m_valid [8];

  exec_cdb_unit_if bus ();

  exec_cdb_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input bit imm, input bit [2:0] f3, input bit f7,
                                          input bit [31:0] a, input bit [31:0] b);
    longint two32 = 64'sh1_0000_0000;
    longint ua = longint'(a);
    longint ub = longint'(b);
    longint sa = (ua >= 64'sh8000_0000) ? ua - two32 : ua;
    longint sb = (ub >= 64'sh8000_0000) ? ub - two32 : ub;
    longint d  = 64'sd1 << b[4:0];
    longint r;
    case (f3)
      3'd0: r = (!imm && f7) ? ua - ub : ua + ub;
      3'd1: r = ua * d;
      3'd2: r = (sa < sb) ? 1 : 0;
      3'd3: r = (ua < ub) ? 1 : 0;
      3'd4: r = longint'(a ^ b);
      3'd5: r = !f7 ? ua / d : (sa >= 0 ? sa / d : -((-sa + d - 1) / d));
      3'd6: r = longint'(a | b);
      default: r = longint'(a & b);
    endcase
    return r[31:0];
  endfunction

  function automatic logic [31:0] lane_ref(input int l);
    return ref_alu(bus.op_imm[l], bus.funct3[l], bus.funct7_b5[l], bus.src1[l], bus.src2[l]);
  endfunction

  task automatic model_reset();
    for (int t = 0; t < 8; t++) begin
      m_data[t]  = '0;
      m_valid[t] = 1'b0;
    end
  endtask

  task automatic model_clock();
    for (int t = 0; t < 8; t++) begin
      int winner = -1;
      for (int l = 0; l < 4; l++)
        if (bus.exec[l] && bus.tag[l] == 3'(t)) winner = l;
      if (winner >= 0) begin
        m_data[t]  = lane_ref(winner);
        m_valid[t] = 1'b1;
      end else if (bus.clr_valid[t]) begin
        m_valid[t] = 1'b0;
      end
    end
  endtask

  task automatic check_regs(input string name);
    logic [7:0] exp_v;
    for (int t = 0; t < 8; t++) begin
      exp_v[t] = m_valid[t];
      check($sformatf("%s_data%0d", name, t), bus.cdb_data[t], m_data[t]);
    end
    check({name, "_valid"}, bus.cdb_valid, exp_v);
  endtask

  task automatic check_comb(input string name);
    logic [7:0] exp_m = '0;
    for (int l = 0; l < 4; l++) begin
      check($sformatf("%s_alu%0d", name, l), bus.alu_result[l], lane_ref(l));
      if (bus.exec[l]) exp_m = exp_m | (8'd1 << bus.tag[l]);
    end
    check({name, "_setmask"}, bus.set_rob_valid, exp_m);
  endtask

  task automatic clear_inputs();
    bus.exec = '0; bus.op_imm = '0; bus.funct3 = '0; bus.funct7_b5 = '0;
    bus.src1 = '0; bus.src2 = '0; bus.tag = '0; bus.clr_valid = '0;
  endtask

  task automatic set_lane(input int l, input bit imm, input bit [2:0] f3, input bit f7,
                          input bit [31:0] a, input bit [31:0] b, input bit [2:0] t, input bit ex);
    bus.op_imm[l] = imm; bus.funct3[l] = f3; bus.funct7_b5[l] = f7;
    bus.src1[l] = a; bus.src2[l] = b; bus.tag[l] = t; bus.exec[l] = ex;
  endtask

  task automatic step(input string name);
    @(posedge clk);
    model_clock();
    @(negedge clk);
    check_regs(name);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    clear_inputs();
    model_reset();
    rst = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_regs("reset");
    rst = 1'b0;
    step("idle");

    set_lane(0, 0, 3'b111, 0, 32'h1234, 32'h0, 3'd1, 1);
    #1;
    check("and_res", bus.alu_result[0], 32'h0);
    check("and_mask", bus.set_rob_valid, 8'h02);
    step("and");
    check("and_v", bus.cdb_valid, 8'h02);
    @(negedge clk);

    clear_inputs();
    set_lane(1, 1, 3'b000, 0, 32'h0, 32'd11, 3'd3, 1);
    set_lane(2, 1, 3'b000, 0, 32'h0, 32'd12, 3'd4, 1);
    #1 check_comb("addi");
    step("addi");
    check("addi_d3", bus.cdb_data[3], 32'h0000_000B);
    check("addi_d4", bus.cdb_data[4], 32'h0000_000C);
    check("addi_v", bus.cdb_valid, 8'h1A);

    clear_inputs();
    set_lane(0, 0, 3'b000, 1, 32'd5, 32'd7, 3'd0, 0);
    #1 check("sub", bus.alu_result[0], 32'hFFFF_FFFE);
    set_lane(0, 0, 3'b101, 1, 32'h8000_0000, 32'd4, 3'd0, 0);
    #1 check("sra", bus.alu_result[0], 32'hF800_0000);
    set_lane(0, 1, 3'b101, 1, 32'h8000_0000, 32'd4, 3'd0, 0);
    #1 check("srai", bus.alu_result[0], 32'hF800_0000);
    set_lane(0, 0, 3'b101, 0, 32'h8000_0000, 32'd4, 3'd0, 0);
    #1 check("srl", bus.alu_result[0], 32'h0800_0000);
    set_lane(0, 0, 3'b010, 0, 32'hFFFF_FFFF, 32'd1, 3'd0, 0);
    #1 check("slt", bus.alu_result[0], 32'h1);
    set_lane(0, 0, 3'b011, 0, 32'hFFFF_FFFF, 32'd1, 3'd0, 0);
    #1 check("sltu", bus.alu_result[0], 32'h0);
    check("noexec_mask", bus.set_rob_valid, 8'h00);

    @(negedge clk);
    clear_inputs();
    set_lane(0, 0, 3'b110, 0, 32'hAAAA, 32'h0, 3'd5, 1);
    set_lane(3, 0, 3'b110, 0, 32'h5555, 32'h0, 3'd5, 1);
    #1 check("coll_mask", bus.set_rob_valid, 8'h20);
    step("coll");
    check("coll_d5", bus.cdb_data[5], 32'h5555);

    clear_inputs();
    bus.clr_valid = 8'h20;
    step("clr");
    check("clr_v5", bus.cdb_valid[5], 1'b0);
    check("clr_d5", bus.cdb_data[5], 32'h5555);

    bus.clr_valid = 8'h20;
    set_lane(1, 1, 3'b000, 0, 32'h0, 32'd7, 3'd5, 1);
    step("clrwr");
    check("clrwr_v5", bus.cdb_valid[5], 1'b1);
    check("clrwr_d5", bus.cdb_data[5], 32'd7);

    for (int i = 0; i < 400; i++) begin
      clear_inputs();
      for (int l = 0; l < 4; l++) begin
        logic [31:0] a, b;
        a = $urandom;
        b = $urandom;
        case ($urandom_range(0, 3))
          0: a = 32'h8000_0000 | (a & 32'hF);
          1: b = b & 32'h1F;
          default: ;
        endcase
        set_lane(l, 1'($urandom), 3'($urandom), 1'($urandom), a, b,
                 3'($urandom_range(0, 7)), 1'($urandom_range(0, 2) != 0));
      end
      bus.clr_valid = 8'($urandom & $urandom);
      #1 check_comb("rnd");
      step("rnd");
    end

    clear_inputs();
    set_lane(2, 0, 3'b100, 0, 32'hDEAD_BEEF, 32'h1234_5678, 3'd6, 1);
    #2 rst = 1'b1;
    model_reset();
    #1 check_regs("arst");
    check_comb("arst");
    @(posedge clk);
    @(negedge clk);
    check_regs("arst_hold");
    rst = 1'b0;
    clear_inputs();
    step("post_rst");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/exec_cdb_unit.md
Name: exec_cdb_unit

Overview:
- Execution back-end slice: four parallel RV32I integer ALU lanes feed an 8-entry common data bus (CDB) indexed by ROB tag.
- Each lane takes an operand word dispatched by its reservation station and computes a result combinationally. The result is latched into the CDB slot selected by its ROB tag.
- Reservation stations and the ROB read the per-tag data and valid status.
- The block also produces the per-cycle set-valid mask the ROB uses to mark entries complete.

Parameters:
- NUM_LANES, 4, number of ALU lanes (fixed at 4 in this revision).
- NUM_TAGS, 8, number of ROB tags / CDB slots; tag width is log2(NUM_TAGS)=3.
- XLEN, 32, datapath width.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- exec  in  4  per-lane start-execute strobe from reservation station.
- op_imm  in  4  per lane: 1 = OP-IMM encoding, 0 = OP (register-register).
- funct3  in  4x3  per-lane funct3.
- funct7_b5  in  4  per-lane instruction bit 30.
- src1  in  4x32  per-lane operand 1.
- src2  in  4x32  per-lane operand 2 (sign-extended immediate when op_imm=1).
- tag  in  4x3  per-lane destination ROB tag.
- clr_valid  in  8  per-tag clear of CDB valid (ROB commit/free).
- alu_result  out  4x32  combinational per-lane ALU result.
- set_rob_valid  out  8  combinational mask; bit t=1 when any lane with exec=1 has tag=t.
- cdb_data  out  8x32  registered CDB data per tag.
- cdb_valid  out  8  registered CDB valid per tag.

Behaviour:
ALU (combinational, per lane, independent of exec), by funct3:
- 000: ADD; SUB when op_imm=0 and funct7_b5=1.
- 001: SLL by src2[4:0].
- 010: SLT, signed; result is 1 or 0.
- 011: SLTU, unsigned.
- 100: XOR.
- 101: SRL; SRA when funct7_b5=1, for both OP and OP-IMM.
- 110: OR.
- 111: AND.
- All arithmetic is modulo 2^32; overflow is ignored.

CDB write:
- On a rising clk, for every lane with exec=1: cdb_data[tag] <= alu_result and cdb_valid[tag] <= 1.
- Write latency is 1 cycle; data is visible the cycle after exec.
- Slots not written hold their value.
- Tag collision (two or more lanes with exec=1 and the same tag): the highest-numbered lane wins (lane 3 > 2 > 1 > 0).
- clr_valid[t]=1 clears cdb_valid[t] on the clock edge; cdb_data is unchanged.
- Same-cycle write and clr_valid on one tag: the write wins and valid is set.

set_rob_valid:
- Pure OR of one-hot(tag) over lanes with exec=1; no clock dependence.

Reset:
- rst asserts asynchronously and immediately forces all cdb_data to 0 and all cdb_valid to 0.
- Reset mid-operation discards in-flight writes.
- Deassertion is synchronised by the integrator.
- Combinational outputs follow their inputs during reset.

Test Plan:
- Reset: assert rst for 5 cycles -> all cdb_data=0x00000000, cdb_valid=0x00; release, no exec -> values hold.
- Lane0 AND (op_imm=0, f3=111) src1=0x1234, src2=0, tag=1, exec=1 -> alu_result[0]=0 combinationally; set_rob_valid=0x02; next cycle cdb_data[1]=0, cdb_valid=0x02.
- Lane1 ADDI src1=0, src2=11, tag=3 and lane2 ADDI src1=0, src2=12, tag=4 in the same cycle -> cdb_data[3]=0x0000000B, cdb_data[4]=0x0000000C, cdb_valid bits 3 and 4 set.
- Lane0 SUB 5-7 -> 0xFFFFFFFE; SRA 0x80000000 by 4 -> 0xF8000000; SRL same -> 0x08000000; SLT(-1,1) -> 1; SLTU(-1,1) -> 0.
- Collision: lane0 and lane3 both exec with tag=5, results 0xAAAA and 0x5555 -> cdb_data[5]=0x5555; set_rob_valid=0x20.
- clr_valid[5]=1 with no write -> cdb_valid[5]=0, cdb_data[5] retained. Repeat with a same-cycle write to tag 5 -> cdb_valid[5]=1. Assert rst mid-cycle -> outputs zero without waiting for a clock.
